// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// scan FSM state type, blanking constants and the hex glyph table.
package display_scan_ctrl_pkg;

    // Each digit slot opens with a dead-time phase, then drives its digit.
    typedef enum logic [0:0] {
        StBlank = 1'b0,
        StDrive = 1'b1
    } scan_state_e;

    // Active-low outputs: all ones means dark.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; entry n is hex digit n.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Glyph lookup for one hex nibble.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
        return HEX_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Scan timebase: slot cycle counter, digit index and the BLANK/DRIVE
// phase FSM. Emits a strobe on the last cycle of every slot and on the
// last cycle of the digit-3 slot (frame boundary).
module display_scan_ctrl_scan_timer
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [1:0]  idx,
    output scan_state_e state,
    output logic        slot_wrap,
    output logic        frame_wrap
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    scan_state_e      state_q, state_d;

    assign slot_wrap  = (cnt_q == CNT_MAX);
    assign frame_wrap = slot_wrap && (idx_q == 2'd3);

    assign idx   = idx_q;
    assign state = state_q;

    // Slot counter wraps at SCAN_DIV-1; digit index steps on each wrap.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Phase FSM: enter DRIVE when the counter reaches BLANK_CYC, fall back
    // to BLANK when it restarts a slot.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBlank: begin
                if (cnt_d >= CNT_BLANK) begin
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (cnt_d < CNT_BLANK) begin
                    state_d = StBlank;
                end
            end
        endcase
    end

    // Timebase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= StBlank;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment display controller.
// A loaded value is parked in a shadow register and only becomes the
// displayed (active) value at a frame boundary, so a frame never mixes
// digits of two values. an/seg/frame_start are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN -- keep leading zero digits
// (all but digit 0) dark.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    output logic        pending,
    output logic        frame_start,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    logic [1:0]  idx;
    scan_state_e state;
    logic        slot_wrap;
    logic        frame_wrap;

    logic [15:0] shadow_q, shadow_d;
    logic [15:0] active_q, active_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        frame_start_q, frame_start_d;

    logic [3:0]  digit_val;
    logic        digit_lit;

    display_scan_ctrl_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_scan_timer (
        .clk        (clk),
        .rst        (rst),
        .idx        (idx),
        .state      (state),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap)
    );

    // Only frame boundaries matter here; the per-slot strobe is not needed.
    logic unused_slot_wrap;
    assign unused_slot_wrap = slot_wrap;

    // Load lands in the shadow; the frame boundary copies shadow to active.
    // A load on the boundary cycle passes straight through to active.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end
        if (frame_wrap) begin
            active_d  = shadow_d;
            pending_d = 1'b0;
        end
    end

    // Select the nibble of the digit currently being scanned.
    always_comb begin
        digit_val = active_q[3:0];
        unique case (idx)
            2'd0: digit_val = active_q[3:0];
            2'd1: digit_val = active_q[7:4];
            2'd2: digit_val = active_q[11:8];
            2'd3: digit_val = active_q[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        digit_lit = 1'b1;
        unique case (idx)
            2'd0: digit_lit = 1'b1;
            2'd1: digit_lit = |active_q[15:4];
            2'd2: digit_lit = |active_q[15:8];
            2'd3: digit_lit = |active_q[15:12];
        endcase
    end
`else
    assign digit_lit = 1'b1;
`endif

    // Next output pattern: dark during dead time, one anode plus glyph otherwise.
    always_comb begin
        an_d          = AN_OFF;
        seg_d         = SEG_BLANK;
        frame_start_d = frame_wrap;
        if ((state == StDrive) && digit_lit) begin
            an_d[idx] = 1'b0;
            seg_d     = hex_glyph(digit_val);
        end
    end

    // Value registers and registered outputs; reset blanks immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pending     = pending_q;
    assign frame_start = frame_start_q;
    assign an          = an_q;
    assign seg         = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
// The reference model tracks the absolute cycle number since reset and
// derives slot position, digit and frame from it arithmetically.
module tb_display_scan_ctrl;

    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned FRAME     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic        pending;
    logic        frame_start;
    logic [3:0]  an;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;

    // Model state.
    int unsigned k;
    logic [15:0] m_active, m_shadow;
    logic        m_pending;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fs;

    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    display_scan_ctrl #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value_in    (value_in),
        .pending     (pending),
        .frame_start (frame_start),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        k         = 0;
        m_active  = 16'h0000;
        m_shadow  = 16'h0000;
        m_pending = 1'b0;
        e_an      = 4'b1111;
        e_seg     = 7'b1111111;
        e_fs      = 1'b0;
    endtask

    // Expected registered outputs produced from cycle k.
    task automatic predict();
        int unsigned pos;
        int unsigned d;
        logic [15:0] hi;
        bit lit;
        pos = k % SCAN_DIV;
        d   = (k / SCAN_DIV) % 4;
        hi  = m_active >> (4 * d);
        lit = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        lit = (d == 0) || (hi != 16'h0000);
`endif
        e_fs = ((k % FRAME) == FRAME - 1);
        if (pos < BLANK_CYC || !lit) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
        end else begin
            e_an  = ~(4'b0001 << d);
            e_seg = glyph[hi[3:0]];
        end
    endtask

    // One clock: drive inputs for cycle k, advance the model, settle.
    task automatic tick(input logic ld, input logic [15:0] val);
        load     = ld;
        value_in = val;
        @(posedge clk);
        predict();
        if (ld) begin
            m_shadow  = val;
            m_pending = 1'b1;
        end
        if ((k % FRAME) == FRAME - 1) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        k++;
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        if (an !== 4'b1111) begin
            errors++; $display("FAIL reset_an: got %b expected 1111", an);
        end
        checks++;
        if (seg !== 7'b1111111) begin
            errors++; $display("FAIL reset_seg: got %b expected 1111111", seg);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending: got %b expected 0", pending);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start);
        end
        checks++;
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        int last_fs;
        int fs_count;
        last_fs  = -1;
        fs_count = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1'b0, 16'h0000);
            if ({an, seg, pending, frame_start} !== {e_an, e_seg, m_pending, e_fs}) begin
                errors++;
                $display("FAIL free_run k=%0d: an=%b seg=%b pend=%b fs=%b, expected %b %b %b %b",
                         k - 1, an, seg, pending, frame_start, e_an, e_seg, m_pending, e_fs);
            end
            checks++;
            if (frame_start === 1'b1) begin
                fs_count++;
                if (last_fs >= 0) begin
                    if (int'(k - 1) - last_fs != int'(FRAME)) begin
                        errors++;
                        $display("FAIL frame_period: got %0d expected %0d",
                                 int'(k - 1) - last_fs, FRAME);
                    end
                    checks++;
                end
                last_fs = int'(k - 1);
            end
        end
        if (fs_count != 3) begin
            errors++; $display("FAIL frame_count: got %0d expected 3", fs_count);
        end
        checks++;
    endtask

    task automatic test_load_display();
        bit seen_fs;
        bit found;
        repeat ($urandom_range(0, FRAME - 1)) tick(1'b0, 16'h0000);
        while ((k % FRAME) == FRAME - 1) tick(1'b0, 16'h0000);
        tick(1'b1, 16'h1234);
        if (pending !== 1'b1) begin
            errors++; $display("FAIL load_pending: got %b expected 1", pending);
        end
        checks++;
        seen_fs = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick(1'b0, 16'h0000);
            if ({an, seg, pending, frame_start} !== {e_an, e_seg, m_pending, e_fs}) begin
                errors++;
                $display("FAIL load_display k=%0d: an=%b seg=%b pend=%b fs=%b, expected %b %b %b %b",
                         k - 1, an, seg, pending, frame_start, e_an, e_seg, m_pending, e_fs);
            end
            checks++;
            if (frame_start === 1'b1) seen_fs = 1'b1;
            if (seen_fs && an === 4'b1110) begin
                found = 1'b1;
                if (seg !== 7'b0011001) begin
                    errors++; $display("FAIL load_digit0: got seg=%b expected 0011001", seg);
                end
                checks++;
            end
        end
        if (!found) begin
            errors++; $display("FAIL load_digit0_timeout: digit 0 never driven after frame_start");
        end
        checks++;
    endtask

    task automatic test_last_wins();
        int bad;
        bad = 0;
        while (!(((k / SCAN_DIV) % 4) == 1 && (k % SCAN_DIV) == 3)) tick(1'b0, 16'h0000);
        tick(1'b1, 16'h00AB);
        while (((k / SCAN_DIV) % 4) != 2) tick(1'b0, 16'h0000);
        tick(1'b1, 16'h5678);
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 16'h0000);
            if ({an, seg, pending, frame_start} !== {e_an, e_seg, m_pending, e_fs}) begin
                errors++;
                $display("FAIL last_wins k=%0d: an=%b seg=%b pend=%b fs=%b, expected %b %b %b %b",
                         k - 1, an, seg, pending, frame_start, e_an, e_seg, m_pending, e_fs);
            end
            checks++;
            if (seg === 7'b0001000 || seg === 7'b0000011) bad++;
        end
        if (bad != 0) begin
            errors++; $display("FAIL last_wins_no_ab: got %0d A/b glyphs expected 0", bad);
        end
        checks++;
    endtask

    task automatic test_commit_load();
        bit found;
        found = 1'b0;
        while ((k % FRAME) != FRAME - 1) tick(1'b0, 16'h0000);
        tick(1'b1, 16'h8888);
        if (pending !== 1'b0) begin
            errors++; $display("FAIL commit_load_pending: got %b expected 0", pending);
        end
        checks++;
        for (int i = 0; i < FRAME && !found; i++) begin
            tick(1'b0, 16'h0000);
            if ({an, seg, pending, frame_start} !== {e_an, e_seg, m_pending, e_fs}) begin
                errors++;
                $display("FAIL commit_load k=%0d: an=%b seg=%b pend=%b fs=%b, expected %b %b %b %b",
                         k - 1, an, seg, pending, frame_start, e_an, e_seg, m_pending, e_fs);
            end
            checks++;
            if (an === 4'b1110) begin
                found = 1'b1;
                if (seg !== 7'b0000000) begin
                    errors++; $display("FAIL commit_load_digit0: got seg=%b expected 0000000", seg);
                end
                checks++;
            end
        end
        if (!found) begin
            errors++; $display("FAIL commit_load_timeout: digit 0 never driven");
        end
        checks++;
    endtask

    task automatic test_random();
        logic        ld;
        logic [15:0] val;
        for (int i = 0; i < 400; i++) begin
            ld  = ($urandom_range(0, 5) == 0);
            val = 16'($urandom);
            tick(ld, val);
            if ({an, seg, pending, frame_start} !== {e_an, e_seg, m_pending, e_fs}) begin
                errors++;
                $display("FAIL random k=%0d: an=%b seg=%b pend=%b fs=%b, expected %b %b %b %b",
                         k - 1, an, seg, pending, frame_start, e_an, e_seg, m_pending, e_fs);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid_drive();
        int bad;
        bad = 0;
        while ((k % FRAME) >= FRAME - SCAN_DIV) tick(1'b0, 16'h0000);
        tick(1'b1, 16'hABCD);
        while ((k % SCAN_DIV) != 5) tick(1'b0, 16'h0000);
        if ({an, pending} !== {e_an, m_pending}) begin
            errors++; $display("FAIL pre_reset: an=%b pend=%b expected %b %b",
                               an, pending, e_an, m_pending);
        end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        if (an !== 4'b1111) begin
            errors++; $display("FAIL midreset_an: got %b expected 1111", an);
        end
        checks++;
        if (seg !== 7'b1111111) begin
            errors++; $display("FAIL midreset_seg: got %b expected 1111111", seg);
        end
        checks++;
        if (pending !== 1'b0) begin
            errors++; $display("FAIL midreset_pending: got %b expected 0", pending);
        end
        checks++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick(1'b0, 16'h0000);
            if ({an, seg, pending, frame_start} !== {e_an, e_seg, m_pending, e_fs}) begin
                errors++;
                $display("FAIL after_reset k=%0d: an=%b seg=%b pend=%b fs=%b, expected %b %b %b %b",
                         k - 1, an, seg, pending, frame_start, e_an, e_seg, m_pending, e_fs);
            end
            checks++;
            if (an !== 4'b1111 && seg !== 7'b1000000) bad++;
        end
        if (bad != 0) begin
            errors++; $display("FAIL after_reset_zero: got %0d non-zero glyphs expected 0", bad);
        end
        checks++;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_leading_zero();
        logic [15:0] vals [2];
        vals[0] = 16'h0007;
        vals[1] = 16'h0000;
        for (int v = 0; v < 2; v++) begin
            while ((k % FRAME) == FRAME - 1) tick(1'b0, 16'h0000);
            tick(1'b1, vals[v]);
            for (int i = 0; i < 2 * FRAME; i++) begin
                tick(1'b0, 16'h0000);
                if ({an, seg, pending, frame_start} !== {e_an, e_seg, m_pending, e_fs}) begin
                    errors++;
                    $display("FAIL lzb k=%0d: an=%b seg=%b pend=%b fs=%b, expected %b %b %b %b",
                             k - 1, an, seg, pending, frame_start, e_an, e_seg, m_pending, e_fs);
                end
                checks++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_load_display();
        test_last_wins();
        test_commit_load();
        test_random();
        test_reset_mid_drive();
`ifdef LEADING_ZERO_BLANK_EN
        test_leading_zero();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
